// File: rtl/ecc_sram_secded_if.sv
// ecc_sram_secded_if
//   Signal bundle between a load/store requester and the ECC-protected RAM.
//   Widths follow the parameters, so the instance parameters must match
//   those of the ecc_sram_secded instance it connects to.
//
//   master modport (requester):
//     out: wr_en, wr_addr, wr_data, inj_mask, rd_en, rd_addr, cnt_clr
//     in : rd_valid, rd_data, single_err, double_err, err_count, scrub_busy
//   slave modport (memory): the same signals with directions reversed.
//
//   Codeword width CODE_W = DATA_W + P + 1, where P is the smallest number
//   of Hamming check bits with 2**P >= DATA_W + P + 1 (32 data bits -> 39).

interface ecc_sram_secded_if #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 256,
   parameter int CNT_W  = 8
);

   function automatic int calc_p(input int dw);
      int p;
      p = 1;
      while ((1 << p) < (dw + p + 1)) begin
         p = p + 1;
      end
      return p;
   endfunction

   localparam int ADDR_W = $clog2(DEPTH);
   localparam int CODE_W = DATA_W + calc_p(DATA_W) + 1;

   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic [CODE_W-1:0] inj_mask;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic              rd_valid;
   logic [DATA_W-1:0] rd_data;
   logic              single_err;
   logic              double_err;
   logic [CNT_W-1:0]  err_count;
   logic              cnt_clr;
   logic              scrub_busy;

   modport master (
      output wr_en, wr_addr, wr_data, inj_mask, rd_en, rd_addr, cnt_clr,
      input  rd_valid, rd_data, single_err, double_err, err_count, scrub_busy
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, inj_mask, rd_en, rd_addr, cnt_clr,
      output rd_valid, rd_data, single_err, double_err, err_count, scrub_busy
   );

endinterface

// File: rtl/ecc_sram_secded.sv
// ecc_sram_secded
//   SECDED-protected word memory with independent read and write ports.
//   Write data is Hamming-encoded (check bits at power-of-two positions,
//   overall parity in the codeword MSB) and XORed with inj_mask before it is
//   stored. Reads are checked and single-bit errors corrected; double-bit
//   errors are flagged and the raw data bits are returned. Flagged reads are
//   counted in a saturating counter.
//
//   Parameters: DATA_W (4..64), DEPTH, RD_LAT (1 or 2), CNT_W.
//
//   Ports:
//     clk  - rising-edge clock
//     rst  - synchronous active-high reset (output state, counter, scrub slot;
//            the array itself is never reset)
//     bus  - ecc_sram_secded_if.slave: write port (wr_en/wr_addr/wr_data/
//            inj_mask), read port (rd_en/rd_addr -> rd_valid/rd_data/
//            single_err/double_err after RD_LAT cycles), err_count/cnt_clr,
//            scrub_busy.
//
//   Optional feature, macro ECC_SCRUB_EN:
//     defined   - a corrected single-bit read is re-encoded and written back
//                 on the first cycle without a user write (scrub_busy shows
//                 the pending write-back).
//     undefined - no write-back; scrub_busy is tied low.
//
//   Codeword layout: bit i of the Hamming field (bits CODE_W-2..0) holds
//   Hamming position i+1, so check bit j lives at bit (2**j)-1 and data bits
//   fill the remaining positions in ascending order.

module ecc_sram_secded #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 256,
   parameter int RD_LAT = 1,
   parameter int CNT_W  = 8
) (
   input  logic             clk,
   input  logic             rst,
   ecc_sram_secded_if.slave bus
);

   function automatic int calc_p(input int dw);
      int p;
      p = 1;
      while ((1 << p) < (dw + p + 1)) begin
         p = p + 1;
      end
      return p;
   endfunction

   localparam int ADDR_W = $clog2(DEPTH);
   localparam int P      = calc_p(DATA_W);
   localparam int H_W    = DATA_W + P;     // Hamming field without overall parity
   localparam int CODE_W = H_W + 1;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // Positions covered by check bit j: every position whose index has bit j set.
   function automatic logic [H_W-1:0] cover_mask(input int j);
      logic [H_W-1:0] m;
      for (int i = 0; i < H_W; i++) begin
         m[i] = (((i + 1) >> j) % 2) == 1;
      end
      return m;
   endfunction

   if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_rd_lat
      $fatal(1, "ecc_sram_secded: RD_LAT must be 1 or 2");
   end

   if (DATA_W < 4 || DATA_W > 64) begin : g_bad_data_w
      $fatal(1, "ecc_sram_secded: DATA_W must be within 4..64");
   end

   // ------------------------------------------------------------------
   // Encoder (write path) and syndrome (read path)
   // ------------------------------------------------------------------
   logic [H_W-1:0]    wr_hd;      // write data placed, check positions zero
   logic [H_W-1:0]    wr_hf;      // full Hamming field incl. check bits
   logic [P-1:0]      wr_par;
   logic [CODE_W-1:0] wr_code;

   logic [CODE_W-1:0] rd_code_q;  // registered array output
   logic [H_W-1:0]    rd_h;
   logic [P-1:0]      syn;
   logic              par_err;
   logic [DATA_W-1:0] dec_data;
   logic              dec_single;
   logic              dec_double;

   // final (output-stage) view of a read
   logic              fin_valid;
   logic [DATA_W-1:0] fin_data;
   logic              fin_single;
   logic              fin_double;

`ifdef ECC_SCRUB_EN
   logic [H_W-1:0]    sc_hd;
   logic [H_W-1:0]    sc_hf;
   logic [P-1:0]      sc_par;
   logic [CODE_W-1:0] sc_code;    // fresh encode of the corrected read data
   logic [ADDR_W-1:0] fin_addr;
`endif

   assign rd_h = rd_code_q[H_W-1:0];

   genvar gi;
   for (gi = 0; gi < P; gi++) begin : g_par
      localparam logic [H_W-1:0] COVER = cover_mask(gi);
      assign wr_par[gi] = ^(wr_hd & COVER);
      assign syn[gi]    = ^(rd_h & COVER);
`ifdef ECC_SCRUB_EN
      assign sc_par[gi] = ^(sc_hd & COVER);
`endif
   end

   for (gi = 0; gi < H_W; gi++) begin : g_pos
      if (((gi + 1) & gi) == 0) begin : g_chk
         // position gi+1 is a power of two: a check bit
         assign wr_hd[gi] = 1'b0;
         assign wr_hf[gi] = wr_par[$clog2(gi + 1)];
`ifdef ECC_SCRUB_EN
         assign sc_hd[gi] = 1'b0;
         assign sc_hf[gi] = sc_par[$clog2(gi + 1)];
`endif
      end else begin : g_dat
         // data index = position - (number of check positions below it) - 1
         localparam int DI = gi - $clog2(gi + 2);
         assign wr_hd[gi] = bus.wr_data[DI];
         assign wr_hf[gi] = bus.wr_data[DI];
         // flip only when the parity says an odd number of bits went bad;
         // with good parity and a non-zero syndrome the raw bit is passed on
         assign dec_data[DI] = rd_h[gi] ^ (par_err & (syn == P'(gi + 1)));
`ifdef ECC_SCRUB_EN
         assign sc_hd[gi] = fin_data[DI];
         assign sc_hf[gi] = fin_data[DI];
`endif
      end
   end

   assign wr_code = {^wr_hf, wr_hf} ^ bus.inj_mask;
`ifdef ECC_SCRUB_EN
   assign sc_code = {^sc_hf, sc_hf};
`endif

   // A clean codeword has even overall parity; odd parity means one (or an
   // odd number of) flipped bits, syndrome 0 with odd parity is the MSB itself.
   assign par_err    = ^rd_code_q;
   assign dec_single = par_err;
   assign dec_double = (syn != '0) & ~par_err;

   // ------------------------------------------------------------------
   // Array with a single write port shared by user writes and scrubbing
   // ------------------------------------------------------------------
   logic [CODE_W-1:0] mem [DEPTH];
   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [CODE_W-1:0] mem_wdata;

   logic              pend_q, pend_d;
`ifdef ECC_SCRUB_EN
   logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
   logic [CODE_W-1:0] pend_code_q, pend_code_d;
`endif

   always_comb begin
      mem_we    = bus.wr_en;
      mem_waddr = bus.wr_addr;
      mem_wdata = wr_code;
`ifdef ECC_SCRUB_EN
      // scrub write-back only steals the port when the user is not writing
      if (!bus.wr_en && pend_q) begin
         mem_we    = 1'b1;
         mem_waddr = pend_addr_q;
         mem_wdata = pend_code_q;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

   // Registered read; non-blocking update gives read-first behaviour on a
   // same-address write. Clearing it on reset makes rd_data read back as 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_code_q <= '0;
      end else if (bus.rd_en) begin
         rd_code_q <= mem[bus.rd_addr];
      end
   end

   // ------------------------------------------------------------------
   // Read pipeline
   // ------------------------------------------------------------------
   logic v1_q, v1_d;

   always_comb begin
      v1_d = bus.rd_en;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v1_q <= 1'b0;
      end else begin
         v1_q <= v1_d;
      end
   end

`ifdef ECC_SCRUB_EN
   logic [ADDR_W-1:0] addr1_q, addr1_d;

   always_comb begin
      addr1_d = bus.rd_en ? bus.rd_addr : addr1_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         addr1_q <= '0;
      end else begin
         addr1_q <= addr1_d;
      end
   end
`endif

   if (RD_LAT == 1) begin : g_lat1
      assign fin_valid  = v1_q;
      assign fin_data   = dec_data;
      assign fin_single = v1_q & dec_single;
      assign fin_double = v1_q & dec_double;
`ifdef ECC_SCRUB_EN
      assign fin_addr   = addr1_q;
`endif
   end else begin : g_lat2
      logic              out_valid_q,  out_valid_d;
      logic [DATA_W-1:0] out_data_q,   out_data_d;
      logic              out_single_q, out_single_d;
      logic              out_double_q, out_double_d;

      always_comb begin
         out_valid_d  = v1_q;
         out_data_d   = v1_q ? dec_data : out_data_q;
         out_single_d = v1_q & dec_single;
         out_double_d = v1_q & dec_double;
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_single_q <= 1'b0;
            out_double_q <= 1'b0;
         end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_single_q <= out_single_d;
            out_double_q <= out_double_d;
         end
      end

      assign fin_valid  = out_valid_q;
      assign fin_data   = out_data_q;
      assign fin_single = out_single_q;
      assign fin_double = out_double_q;

`ifdef ECC_SCRUB_EN
      logic [ADDR_W-1:0] out_addr_q, out_addr_d;

      always_comb begin
         out_addr_d = v1_q ? addr1_q : out_addr_q;
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            out_addr_q <= '0;
         end else begin
            out_addr_q <= out_addr_d;
         end
      end

      assign fin_addr = out_addr_q;
`endif
   end

   // ------------------------------------------------------------------
   // Saturating error counter; clear beats a same-cycle increment
   // ------------------------------------------------------------------
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (bus.cnt_clr) begin
         cnt_d = '0;
      end else if ((fin_single || fin_double) && cnt_q != CNT_MAX) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // ------------------------------------------------------------------
   // Scrub slot
   // ------------------------------------------------------------------
`ifdef ECC_SCRUB_EN
   always_comb begin
      pend_d      = pend_q;
      pend_addr_d = pend_addr_q;
      pend_code_d = pend_code_q;
      if (pend_q) begin
         if (bus.wr_en) begin
            // newer user data for the same word supersedes the scrub
            if (bus.wr_addr == pend_addr_q) begin
               pend_d = 1'b0;
            end
         end else begin
            pend_d = 1'b0;   // written back this cycle
         end
      end else if (fin_single) begin
         pend_d      = 1'b1;
         pend_addr_d = fin_addr;
         pend_code_d = sc_code;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pend_q      <= 1'b0;
         pend_addr_q <= '0;
         pend_code_q <= '0;
      end else begin
         pend_q      <= pend_d;
         pend_addr_q <= pend_addr_d;
         pend_code_q <= pend_code_d;
      end
   end
`else
   always_comb begin
      pend_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pend_q <= 1'b0;
      end else begin
         pend_q <= pend_d;
      end
   end
`endif

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign bus.rd_valid   = fin_valid;
   assign bus.rd_data    = fin_data;
   assign bus.single_err = fin_single;
   assign bus.double_err = fin_double;
   assign bus.err_count  = cnt_q;
   assign bus.scrub_busy = pend_q;

endmodule

// File: tb/tb_ecc_sram_secded.sv
// Testbench for ecc_sram_secded with three instances:
//   dut_a: RD_LAT=1, CNT_W=8  (basic decode cases, read-first, scrub)
//   dut_b: RD_LAT=2, CNT_W=8  (pipelined reads, reset mid-stream)
//   dut_c: RD_LAT=1, CNT_W=2  (counter saturation and clear priority)
// Codeword bit i carries Hamming position i+1; bit 38 is overall parity.

module tb_ecc_sram_secded;

`ifdef ECC_SCRUB_EN
   localparam bit SCRUB = 1'b1;
`else
   localparam bit SCRUB = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a, rst_b, rst_c;

   ecc_sram_secded_if #(.DATA_W(32), .DEPTH(256), .CNT_W(8)) if_a ();
   ecc_sram_secded_if #(.DATA_W(32), .DEPTH(256), .CNT_W(8)) if_b ();
   ecc_sram_secded_if #(.DATA_W(32), .DEPTH(256), .CNT_W(2)) if_c ();

   ecc_sram_secded #(.DATA_W(32), .DEPTH(256), .RD_LAT(1), .CNT_W(8)) dut_a (
      .clk (clk), .rst (rst_a), .bus (if_a));
   ecc_sram_secded #(.DATA_W(32), .DEPTH(256), .RD_LAT(2), .CNT_W(8)) dut_b (
      .clk (clk), .rst (rst_b), .bus (if_b));
   ecc_sram_secded #(.DATA_W(32), .DEPTH(256), .RD_LAT(1), .CNT_W(2)) dut_c (
      .clk (clk), .rst (rst_c), .bus (if_c));

   int n_checks  = 0;
   int n_pass    = 0;
   int exp_cnt_a = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [38:0] bit_mask(input int b);
      logic [38:0] m;
      m = '0;
      m[b] = 1'b1;
      return m;
   endfunction

   task automatic wr(input int which, input logic [7:0] addr, input logic [31:0] data,
                     input logic [38:0] mask);
      case (which)
         0: begin if_a.wr_en = 1'b1; if_a.wr_addr = addr; if_a.wr_data = data; if_a.inj_mask = mask; end
         1: begin if_b.wr_en = 1'b1; if_b.wr_addr = addr; if_b.wr_data = data; if_b.inj_mask = mask; end
         default: begin if_c.wr_en = 1'b1; if_c.wr_addr = addr; if_c.wr_data = data; if_c.inj_mask = mask; end
      endcase
      tick();
      if_a.wr_en = 1'b0; if_a.inj_mask = '0;
      if_b.wr_en = 1'b0; if_b.inj_mask = '0;
      if_c.wr_en = 1'b0; if_c.inj_mask = '0;
      $display("write dut%0d @%0d data=0x%08h inj=0x%010h", which, addr, data, mask);
   endtask

   // one read on dut_a, then the flags/data and the counter one cycle later
   task automatic a_read_check(input string tag, input logic [7:0] addr, input logic [31:0] exp_data,
                               input logic exp_s, input logic exp_d);
      if_a.rd_en   = 1'b1;
      if_a.rd_addr = addr;
      tick();
      if_a.rd_en = 1'b0;
      $display("read  dutA @%0d -> valid=%0b data=0x%08h single=%0b double=%0b",
               addr, if_a.rd_valid, if_a.rd_data, if_a.single_err, if_a.double_err);
      check({tag, " valid"},  64'(if_a.rd_valid),   64'(1'b1));
      check({tag, " data"},   64'(if_a.rd_data),    64'(exp_data));
      check({tag, " single"}, 64'(if_a.single_err), 64'(exp_s));
      check({tag, " double"}, 64'(if_a.double_err), 64'(exp_d));
      if (exp_s || exp_d) exp_cnt_a++;
      tick();
      check({tag, " count"}, 64'(if_a.err_count), 64'(exp_cnt_a));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach the end");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
      if_a.wr_en = 0; if_a.wr_addr = '0; if_a.wr_data = '0; if_a.inj_mask = '0;
      if_a.rd_en = 0; if_a.rd_addr = '0; if_a.cnt_clr = 0;
      if_b.wr_en = 0; if_b.wr_addr = '0; if_b.wr_data = '0; if_b.inj_mask = '0;
      if_b.rd_en = 0; if_b.rd_addr = '0; if_b.cnt_clr = 0;
      if_c.wr_en = 0; if_c.wr_addr = '0; if_c.wr_data = '0; if_c.inj_mask = '0;
      if_c.rd_en = 0; if_c.rd_addr = '0; if_c.cnt_clr = 0;
      tick();
      tick();
      rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
      tick();

      // reset state
      check("rst rd_valid",   64'(if_a.rd_valid),   64'(0));
      check("rst rd_data",    64'(if_a.rd_data),    64'(0));
      check("rst single_err", 64'(if_a.single_err), 64'(0));
      check("rst double_err", 64'(if_a.double_err), 64'(0));
      check("rst err_count",  64'(if_a.err_count),  64'(0));
      check("rst scrub_busy", 64'(if_a.scrub_busy), 64'(0));
      check("rst b valid",    64'(if_b.rd_valid),   64'(0));

      // T1 clean word
      wr(0, 8'd5, 32'hDEADBEEF, '0);
      a_read_check("T1", 8'd5, 32'hDEADBEEF, 1'b0, 1'b0);
      check("T1 valid drops", 64'(if_a.rd_valid), 64'(0));

      // T2 check-bit flip (position 4)
      wr(0, 8'd7, 32'h12345678, bit_mask(3));
      a_read_check("T2", 8'd7, 32'h12345678, 1'b1, 1'b0);

      // T3 double error: positions 4 and 11; position 11 is data bit 6
      wr(0, 8'd9, 32'h00000000, bit_mask(3) | bit_mask(10));
      a_read_check("T3", 8'd9, 32'h00000040, 1'b0, 1'b1);

      // T4 overall parity bit flip
      wr(0, 8'd11, 32'hA5A50F0F, bit_mask(38));
      a_read_check("T4", 8'd11, 32'hA5A50F0F, 1'b1, 1'b0);

      // data-bit single error (position 21) and check bit at position 1
      wr(0, 8'd12, 32'hCAFEF00D, bit_mask(20));
      a_read_check("data flip", 8'd12, 32'hCAFEF00D, 1'b1, 1'b0);
      wr(0, 8'd13, 32'hFFFFFFFF, bit_mask(0));
      a_read_check("pos1 flip", 8'd13, 32'hFFFFFFFF, 1'b1, 1'b0);

      // double error on positions 3 and 5 (data bits 0 and 1) -> raw data
      wr(0, 8'd14, 32'hFFFFFFFF, bit_mask(2) | bit_mask(4));
      a_read_check("dbl data", 8'd14, 32'hFFFFFFFC, 1'b0, 1'b1);

      // read-first on a same-cycle same-address write
      if_a.wr_en = 1'b1; if_a.wr_addr = 8'd5; if_a.wr_data = 32'h11111111;
      if_a.rd_en = 1'b1; if_a.rd_addr = 8'd5;
      tick();
      if_a.wr_en = 1'b0; if_a.rd_en = 1'b0;
      $display("rw    dutA @5 -> data=0x%08h", if_a.rd_data);
      check("rdfirst old", 64'(if_a.rd_data), 64'(32'hDEADBEEF));
      tick();
      a_read_check("rdfirst new", 8'd5, 32'h11111111, 1'b0, 1'b0);

      // T6 scrub behaviour
      wr(0, 8'd4, 32'h0BADF00D, bit_mask(5));
      a_read_check("T6 first", 8'd4, 32'h0BADF00D, 1'b1, 1'b0);
      check("T6 busy", 64'(if_a.scrub_busy), 64'(SCRUB));
      tick();
      check("T6 busy clr", 64'(if_a.scrub_busy), 64'(0));
      a_read_check("T6 reread", 8'd4, 32'h0BADF00D, !SCRUB, 1'b0);

      if_a.cnt_clr = 1'b1;
      tick();
      if_a.cnt_clr = 1'b0;
      check("A cnt_clr", 64'(if_a.err_count), 64'(0));

      // T5 RD_LAT=2 pipelined reads
      wr(1, 8'd1, 32'h1111AAAA, '0);
      wr(1, 8'd2, 32'h2222BBBB, bit_mask(7));
      wr(1, 8'd3, 32'h3333CCCC, '0);
      if_b.rd_en = 1'b1; if_b.rd_addr = 8'd1;
      tick();
      check("T5 lat not 1", 64'(if_b.rd_valid), 64'(0));
      if_b.rd_addr = 8'd2;
      tick();
      $display("read  dutB -> valid=%0b data=0x%08h", if_b.rd_valid, if_b.rd_data);
      check("T5 v1", 64'(if_b.rd_valid), 64'(1));
      check("T5 d1", 64'(if_b.rd_data),  64'(32'h1111AAAA));
      check("T5 s1", 64'(if_b.single_err), 64'(0));
      if_b.rd_addr = 8'd3;
      tick();
      if_b.rd_en = 1'b0;
      $display("read  dutB -> valid=%0b data=0x%08h", if_b.rd_valid, if_b.rd_data);
      check("T5 v2", 64'(if_b.rd_valid), 64'(1));
      check("T5 d2", 64'(if_b.rd_data),  64'(32'h2222BBBB));
      check("T5 s2", 64'(if_b.single_err), 64'(1));
      tick();
      $display("read  dutB -> valid=%0b data=0x%08h", if_b.rd_valid, if_b.rd_data);
      check("T5 v3", 64'(if_b.rd_valid), 64'(1));
      check("T5 d3", 64'(if_b.rd_data),  64'(32'h3333CCCC));
      tick();
      check("T5 end", 64'(if_b.rd_valid), 64'(0));
      check("T5 count", 64'(if_b.err_count), 64'(1));

      // reset while two reads are in flight
      if_b.rd_en = 1'b1; if_b.rd_addr = 8'd1;
      tick();
      if_b.rd_addr = 8'd3;
      rst_b = 1'b1;
      tick();
      if_b.rd_en = 1'b0;
      rst_b = 1'b0;
      check("T5 rst count", 64'(if_b.err_count), 64'(0));
      for (int i = 0; i < 4; i++) begin
         check("T5 rst valid", 64'(if_b.rd_valid), 64'(0));
         tick();
      end

      // T7 CNT_W=2 saturation; distinct addresses so scrubbing cannot hide errors
      for (int i = 0; i < 6; i++) begin
         wr(2, 8'(i), 32'h00000055 + 32'(i), bit_mask(3));
      end
      for (int i = 0; i < 5; i++) begin
         if_c.rd_en = 1'b1; if_c.rd_addr = 8'(i);
         tick();
         $display("read  dutC @%0d -> single=%0b count=%0d", i, if_c.single_err, if_c.err_count);
         check("T7 single", 64'(if_c.single_err), 64'(1));
      end
      if_c.rd_en = 1'b0;
      tick();
      check("T7 saturate", 64'(if_c.err_count), 64'(3));
      tick();
      check("T7 hold", 64'(if_c.err_count), 64'(3));
      if_c.rd_en = 1'b1; if_c.rd_addr = 8'd5;
      tick();
      if_c.rd_en = 1'b0;
      check("T7 clr read", 64'(if_c.single_err), 64'(1));
      if_c.cnt_clr = 1'b1;
      tick();
      if_c.cnt_clr = 1'b0;
      check("T7 clr wins", 64'(if_c.err_count), 64'(0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
